// File: rtl/tri_st_add_pkg.sv
// Shared constants and types for the 64-bit store/fixed-point adder slice.
// Bit and byte numbering is big-endian: index 0 is most significant.
package tri_st_add_pkg;

  localparam int ADD_W     = 64;
  localparam int ADD_BYTES = 8;

  typedef logic [0:ADD_BYTES-1] add_byte_t;

endpackage

// File: rtl/tri_st_add_bytesum.sv
// Combinational byte adder: conditional sums for byte carry-in 0 and 1,
// plus the byte generate (carry out with cin=0) and propagate (carry out with cin=1).
module tri_st_add_bytesum (
  input  logic [0:7] a,
  input  logic [0:7] b_eff,
  output logic [0:7] sum0,
  output logic [0:7] sum1,
  output logic       g,
  output logic       p
);

  logic [8:0] w_s0;
  logic [8:0] w_s1;

  assign w_s0 = {1'b0, a} + {1'b0, b_eff};
  assign w_s1 = {1'b0, a} + {1'b0, b_eff} + 9'd1;

  assign sum0 = w_s0[7:0];
  assign sum1 = w_s1[7:0];
  assign g    = w_s0[8];
  assign p    = w_s1[8];

endmodule

// File: rtl/tri_st_add_cspre.sv
// Carry-select precompute stage: registers per-byte conditional sums and byte carry-ins.
// Optional macro TRI_ST_ADD_OVF_EN builds the registered carry-out and signed-overflow flags.
module tri_st_add_cspre
  import tri_st_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [0:ADD_W-1] a,
  input  logic [0:ADD_W-1] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             flush,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [0:ADD_W-1] sum0,
  output logic [0:ADD_W-1] sum1,
  output add_byte_t        ci_b,
  output logic             co,
  output logic             ov
);

  logic [0:ADD_W-1] w_b_eff;
  logic             w_c_eff;
  logic [0:ADD_W-1] w_sum0;
  logic [0:ADD_W-1] w_sum1;
  add_byte_t        w_g;
  add_byte_t        w_p;
  add_byte_t        w_c;
  logic             w_accept;

  logic             r_out_vld;
  logic [0:ADD_W-1] r_sum0;
  logic [0:ADD_W-1] r_sum1;
  add_byte_t        r_ci_b;

  assign w_b_eff = sub ? ~b : b;
  assign w_c_eff = sub | cin;

  for (genvar k = 0; k < ADD_BYTES; k++) begin : g_byte
    tri_st_add_bytesum u_bytesum (
      .a     (a[8*k +: 8]),
      .b_eff (w_b_eff[8*k +: 8]),
      .sum0  (w_sum0[8*k +: 8]),
      .sum1  (w_sum1[8*k +: 8]),
      .g     (w_g[k]),
      .p     (w_p[k])
    );
  end

  // Byte-level lookahead ripples from the least significant byte (7) upward.
  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    logic w_carry;
    w_carry = w_c_eff;
    w_c     = '0;
    for (int k = ADD_BYTES-1; k >= 1; k--) begin
      w_c[k]  = w_carry;
      w_carry = w_g[k] | (w_p[k] & w_carry);
    end
    w_c[0] = w_carry;
  end

  assign in_rdy   = (~r_out_vld | out_rdy) & ~flush;
  assign w_accept = in_vld & in_rdy;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: data registers are reset too, because downstream observes their reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_sum0    <= '0;
      r_sum1    <= '0;
      r_ci_b    <= '1;
    end else if (flush) begin
      r_out_vld <= 1'b0;
    end else if (w_accept) begin
      r_out_vld <= 1'b1;
      r_sum0    <= w_sum0;
      r_sum1    <= w_sum1;
      r_ci_b    <= ~w_c;
    end else if (out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_vld = r_out_vld;
  assign sum0    = r_sum0;
  assign sum1    = r_sum1;
  assign ci_b    = r_ci_b;

`ifdef TRI_ST_ADD_OVF_EN
  logic w_co;
  logic w_c_bit0;
  logic r_co;
  logic r_ov;

  // Carry into bit 0 is recovered from the selected sum bit: s = a ^ b ^ cin.
  assign w_co     = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c_bit0 = (w_c[0] ? w_sum1[0] : w_sum0[0]) ^ a[0] ^ w_b_eff[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_co <= 1'b0;
      r_ov <= 1'b0;
    end else if (!flush && w_accept) begin
      r_co <= w_co;
      r_ov <= w_co ^ w_c_bit0;
    end
  end

  assign co = r_co;
  assign ov = r_ov;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_g[0] ^ w_p[0];
  assign co = 1'b0;
  assign ov = 1'b0;
`endif

endmodule

// File: tb/tb_tri_st_add_cspre.sv
// Scoreboard bench for tri_st_add_cspre: a 64-bit arithmetic reference model feeds
// a queue on each accept; a negedge monitor compares whatever the DUT presents.
module tb_tri_st_add_cspre;
  import tri_st_add_pkg::*;

  logic             clk = 1'b0;
  logic             rst, in_vld, in_rdy, cin, sub, flush, out_vld, out_rdy, co, ov;
  logic [0:ADD_W-1] a, b, sum0, sum1;
  add_byte_t        ci_b;

  typedef struct {
    logic [0:63] sum0;
    logic [0:63] sum1;
    logic [0:7]  ci_b;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed = 0;
  bit   post_rst = 0;

  tri_st_add_cspre dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .sub     (sub),
    .flush   (flush),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .sum0    (sum0),
    .sum1    (sum1),
    .ci_b    (ci_b),
    .co      (co),
    .ov      (ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: plain 65-bit arithmetic on numeric (little-endian) copies of the operands.
  function automatic exp_t model(input logic [0:63] ai, input logic [0:63] bi,
                                 input logic ci, input logic si);
    exp_t        e;
    logic [63:0] an, bn, mask;
    logic [64:0] part, full;
    logic [7:0]  ab, bb, s0, s1;
    logic        c_eff;
    int          n;
    an    = ai;
    bn    = si ? ~bi : bi;
    c_eff = si ? 1'b1 : ci;
    for (int k = 0; k < 8; k++) begin
      n    = 56 - 8*k;
      ab   = an[n +: 8];
      bb   = bn[n +: 8];
      s0   = ab + bb;
      s1   = ab + bb + 8'd1;
      e.sum0[8*k +: 8] = s0;
      e.sum1[8*k +: 8] = s1;
      mask = (64'd1 << n) - 64'd1;
      part = {1'b0, an & mask} + {1'b0, bn & mask} + {64'd0, c_eff};
      e.ci_b[k] = ~part[n];
    end
    full = {1'b0, an} + {1'b0, bn} + {64'd0, c_eff};
`ifdef TRI_ST_ADD_OVF_EN
    e.co = full[64];
    e.ov = (an[63] == bn[63]) && (full[63] != an[63]);
`else
    e.co = 1'b0;
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: compare presented outputs, then advance the model for the coming edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (armed) begin
      exp_rdy = ((sb_q.size() == 0) || out_rdy) && !flush;
      check("out_vld", out_vld, sb_q.size() != 0);
      check("in_rdy", in_rdy, exp_rdy);
      if (post_rst) begin
        check("rst_sum0", sum0, 64'd0);
        check("rst_sum1", sum1, 64'd0);
        check("rst_ci_b", ci_b, 8'hFF);
        check("rst_co", co, 1'b0);
        check("rst_ov", ov, 1'b0);
        post_rst = 0;
      end
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        check("sum0", sum0, e.sum0);
        check("sum1", sum1, e.sum1);
        check("ci_b", ci_b, e.ci_b);
        check("co", co, e.co);
        check("ov", ov, e.ov);
      end
      if (rst) begin
        sb_q.delete();
        post_rst = 1;
      end else if (flush) begin
        sb_q.delete();
      end else begin
        if (sb_q.size() != 0 && out_rdy) void'(sb_q.pop_front());
        if (in_vld && exp_rdy) sb_q.push_back(model(a, b, cin, sub));
      end
    end else if (rst) begin
      armed    = 1;
      post_rst = 1;
    end
  end

  task automatic drive(input logic v, input logic [0:63] ai, input logic [0:63] bi,
                       input logic ci, input logic si, input logic fl, input logic rdy);
    in_vld  = v;
    a       = ai;
    b       = bi;
    cin     = ci;
    sub     = si;
    flush   = fl;
    out_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:63] rand_op();
    logic [0:63] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      3:       v = 64'h8000_0000_0000_0000;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);

    // Directed arithmetic cases, back-to-back with out_rdy held high.
    drive(1, 64'hFF, 64'd1, 0, 0, 0, 1);
    drive(1, 64'd5, 64'd7, 0, 1, 0, 1);
    drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 1);
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Backpressure: accept, stall three cycles with in_vld high, then drain + accept.
    drive(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 0, 0, 0);
    drive(1, 64'h1111, 64'h2222, 0, 0, 0, 0);
    drive(1, 64'h3333, 64'h4444, 0, 1, 0, 0);
    drive(1, 64'h5555, 64'h6666, 1, 0, 0, 0);
    drive(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Flush with a held result, then flush together with an accept attempt.
    drive(1, 64'hAA, 64'h55, 0, 0, 0, 0);
    drive(1, 64'hBB, 64'h66, 0, 0, 1, 0);
    drive(1, 64'hCC, 64'h77, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Reset while a result is held under backpressure.
    drive(1, 64'hDEAD_BEEF, 64'hCAFE, 0, 1, 0, 0);
    rst = 1'b1;
    drive(1, 64'h1234, 64'h5678, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      rst = (i == 1000);
      drive($urandom_range(0, 3) != 0, rand_op(), rand_op(), 1'($urandom),
            1'($urandom), $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;

    repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
